// File: rtl/ysyx_22041211_bus_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
//   owner_e     : which master owns the bus transaction (IFU=0, LSU=1)
//   arb_state_e : arbiter FSM state encoding
//   GntIfu/GntLsu : bit positions inside the one-hot grant vector
package ysyx_22041211_bus_pkg;

    typedef enum logic {
        OwnerIfu = 1'b0,
        OwnerLsu = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

    localparam int unsigned GntIfu = 0;
    localparam int unsigned GntLsu = 1;

endpackage

// File: rtl/ysyx_22041211_arb_grant.sv
// Two-master grant selection for the memory arbiter (purely combinational).
// Ports:
//   ifu_req    : IFU has a pending request
//   lsu_req    : LSU has a pending request
//   last_owner : master served most recently (0 = IFU, 1 = LSU)
//   rr_en      : 1 = round-robin on conflict, 0 = LSU always wins a conflict
//   grant      : one-hot grant, bit GntIfu / bit GntLsu, all-zero when idle
module ysyx_22041211_arb_grant
    import ysyx_22041211_bus_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_req,
    input  logic       last_owner,
    input  logic       rr_en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (ifu_req && lsu_req) begin
            // Conflict: with round-robin, the master not served last wins.
            if (rr_en && (last_owner == OwnerLsu)) begin
                grant[GntIfu] = 1'b1;
            end else begin
                grant[GntLsu] = 1'b1;
            end
        end else if (lsu_req) begin
            grant[GntLsu] = 1'b1;
        end else if (ifu_req) begin
            grant[GntIfu] = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Arbitrates a single memory port between the IFU (fetch) and LSU (load/store).
// At most one transaction is outstanding: IDLE grants, ISSUE presents the
// latched request until memory accepts it, WAIT collects the response and
// forwards it, one cycle later, to the owning master as a single-cycle pulse.
// Build option: define YSYX_22041211_ARB_RR_EN for round-robin on conflicts;
// otherwise the LSU always wins simultaneous requests.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr   : IFU request channel
//   ifu_rsp_valid, ifu_rdata        : IFU response (pulse + held data)
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask : LSU request
//   lsu_rsp_valid, lsu_rdata        : LSU response (pulse + held data)
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask : memory request
//   mem_rsp_valid, mem_rdata        : memory response
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_bus_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_LEN-1:0]     ifu_addr,
    output logic                    ifu_rsp_valid,
    output logic [DATA_LEN-1:0]     ifu_rdata,

    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_LEN-1:0]     lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_LEN-1:0]     lsu_wdata,
    input  logic [DATA_LEN/8-1:0]   lsu_wmask,
    output logic                    lsu_rsp_valid,
    output logic [DATA_LEN-1:0]     lsu_rdata,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_LEN-1:0]     mem_addr,
    output logic                    mem_wen,
    output logic [DATA_LEN-1:0]     mem_wdata,
    output logic [DATA_LEN/8-1:0]   mem_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_LEN-1:0]     mem_rdata
);

`ifdef YSYX_22041211_ARB_RR_EN
    localparam logic RrEn = 1'b1;
`else
    localparam logic RrEn = 1'b0;
`endif

    arb_state_e             state_q, state_d;
    owner_e                 owner_q;        // current owner, doubles as last-served
    logic [ADDR_LEN-1:0]    addr_q;
    logic                   wen_q;
    logic [DATA_LEN-1:0]    wdata_q;
    logic [DATA_LEN/8-1:0]  wmask_q;
    logic                   ifu_rsp_valid_q, lsu_rsp_valid_q;
    logic [DATA_LEN-1:0]    ifu_rdata_q, lsu_rdata_q;

    logic                   idle;
    logic [1:0]             grant;
    logic                   ifu_hs, lsu_hs;
    logic                   rsp_hit;

    ysyx_22041211_arb_grant u_grant (
        .ifu_req    (ifu_req_valid),
        .lsu_req    (lsu_req_valid),
        .last_owner (owner_q),
        .rr_en      (RrEn),
        .grant      (grant)
    );

    assign idle    = (state_q == StIdle);
    // A grant bit is only ever set for a requesting master, so grant implies valid.
    assign ifu_hs  = idle & grant[GntIfu];
    assign lsu_hs  = idle & grant[GntLsu];
    // Responses outside WAIT are stray and dropped.
    assign rsp_hit = (state_q == StWait) & mem_rsp_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ifu_hs || lsu_hs) state_d = StIssue;
            StIssue: if (mem_req_ready)    state_d = StWait;
            StWait:  if (mem_rsp_valid)    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            owner_q         <= OwnerLsu;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            ifu_rdata_q     <= '0;
            lsu_rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (lsu_hs) begin
                owner_q <= OwnerLsu;
                addr_q  <= lsu_addr;
                wen_q   <= lsu_wen;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
            end else if (ifu_hs) begin
                owner_q <= OwnerIfu;
                addr_q  <= ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
            ifu_rsp_valid_q <= rsp_hit && (owner_q == OwnerIfu);
            lsu_rsp_valid_q <= rsp_hit && (owner_q == OwnerLsu);
            if (rsp_hit && (owner_q == OwnerIfu)) ifu_rdata_q <= mem_rdata;
            if (rsp_hit && (owner_q == OwnerLsu)) lsu_rdata_q <= mem_rdata;
        end
    end

    assign ifu_req_ready = ifu_hs;
    assign lsu_req_ready = lsu_hs;
    assign mem_req_valid = (state_q == StIssue);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
module tb_ysyx_22041211_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_ifu_rdata, model_lsu_rdata;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef YSYX_22041211_ARB_RR_EN
    localparam bit RrOn = 1'b1;
`else
    localparam bit RrOn = 1'b0;
`endif

    always #5 clk = ~clk;

    ysyx_22041211_mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    // Raise one master's request and hold it until granted; returns at the
    // falling edge right after the handshake edge with the request dropped.
    task automatic drive_req(input bit is_lsu, input logic [31:0] addr, input logic wen,
                             input logic [31:0] wdata, input logic [3:0] wmask);
        int budget = 0;
        if (is_lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen;
            lsu_wdata = wdata; lsu_wmask = wmask;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
        end
        #1;
        while (!(is_lsu ? lsu_req_ready : ifu_req_ready) && budget < 50) begin
            @(negedge clk); #1; budget++;
        end
        n_cmp++;
        if (budget >= 50) begin
            n_err++; $display("FAIL grant_timeout: lsu=%0d not granted within 50 cycles", is_lsu);
        end
        n_cmp++;
        if ((ifu_req_ready & lsu_req_ready) !== 1'b0) begin
            n_err++; $display("FAIL both_ready: got ifu=%b lsu=%b, want not both 1",
                              ifu_req_ready, lsu_req_ready);
        end
        @(negedge clk);
        if (is_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    endtask

    // Memory model: hold ready low for 'delay' cycles (checking the request
    // stays stable), accept, then return 'data' in the next cycle.
    task automatic serve(input int delay, input logic [31:0] data, input logic [31:0] e_addr,
                         input logic e_wen, input logic [31:0] e_wdata, input logic [3:0] e_wmask);
        int budget = 0;
        while (mem_req_valid !== 1'b1 && budget < 50) begin
            @(negedge clk); budget++;
        end
        for (int i = 0; i <= delay; i++) begin
            n_cmp++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
                {1'b1, e_addr, e_wen, e_wdata, e_wmask}) begin
                n_err++;
                $display("FAIL mem_req[%0d]: got v=%b a=%h w=%b d=%h m=%h want v=1 a=%h w=%b d=%h m=%h",
                         i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                         e_addr, e_wen, e_wdata, e_wmask);
            end
            if (i == delay) mem_req_ready = 1'b1;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        n_cmp++;
        if (mem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL mem_req_drop: got %b want 0", mem_req_valid);
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = data;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
    endtask

    // Called on the cycle the response pulse is due: pops the scoreboard.
    task automatic check_rsp();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL sb_empty: got response with no expectation queued");
            return;
        end
        e = sb.pop_front();
        if (e.is_lsu) model_lsu_rdata = e.data; else model_ifu_rdata = e.data;
        n_cmp++;
        if ({ifu_rsp_valid, lsu_rsp_valid} !== {~e.is_lsu, e.is_lsu}) begin
            n_err++; $display("FAIL rsp_pulse: got ifu=%b lsu=%b want ifu=%b lsu=%b",
                              ifu_rsp_valid, lsu_rsp_valid, ~e.is_lsu, e.is_lsu);
        end
        n_cmp++;
        if ({ifu_rdata, lsu_rdata} !== {model_ifu_rdata, model_lsu_rdata}) begin
            n_err++; $display("FAIL rdata: got ifu=%h lsu=%h want ifu=%h lsu=%h",
                              ifu_rdata, lsu_rdata, model_ifu_rdata, model_lsu_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin
            n_err++; $display("FAIL rsp_one_cycle: got ifu=%b lsu=%b want 0 0",
                              ifu_rsp_valid, lsu_rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        model_ifu_rdata = 0; model_lsu_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid,
             mem_wen} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000",
                              {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                               mem_req_valid, mem_wen});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== 132'h0) begin
            n_err++; $display("FAIL reset_data: got a=%h d=%h m=%h ir=%h lr=%h want all 0",
                              mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata);
        end
    endtask

    task automatic test_ifu_fetch();
        sb.push_back('{is_lsu: 1'b0, data: 32'h0010_0073});
        drive_req(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        serve(0, 32'h0010_0073, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        check_rsp();
    endtask

    task automatic test_lsu_store();
        sb.push_back('{is_lsu: 1'b1, data: 32'h0000_0000});
        drive_req(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        serve(3, 32'h0000_0000, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        check_rsp();
    endtask

    task automatic test_lsu_load();
        sb.push_back('{is_lsu: 1'b1, data: 32'hCAFE_F00D});
        drive_req(1'b1, 32'h8000_2004, 1'b0, 32'h1111_2222, 4'h3);
        serve(1, 32'hCAFE_F00D, 32'h8000_2004, 1'b0, 32'h1111_2222, 4'h3);
        check_rsp();
    endtask

    // Both masters request in the same cycle; the loser must be granted in
    // the very cycle the winner's response pulse appears.
    task automatic test_back_to_back(input bit exp_lsu_first, input logic [31:0] d_first,
                                     input logic [31:0] d_second);
        logic [31:0] ia = 32'h8000_0040;
        logic [31:0] la = 32'h8000_3000;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = ia;
        lsu_req_valid = 1'b1; lsu_addr = la; lsu_wen = 1'b0; lsu_wdata = 0; lsu_wmask = 0;
        #1;
        n_cmp++;
        if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu_first, exp_lsu_first}) begin
            n_err++; $display("FAIL conflict_grant: got ifu=%b lsu=%b want ifu=%b lsu=%b",
                              ifu_req_ready, lsu_req_ready, ~exp_lsu_first, exp_lsu_first);
        end
        sb.push_back('{is_lsu: exp_lsu_first, data: d_first});
        @(negedge clk);
        if (exp_lsu_first) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        n_cmp++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            n_err++; $display("FAIL busy_ready: got ifu=%b lsu=%b want 0 0",
                              ifu_req_ready, lsu_req_ready);
        end
        if (exp_lsu_first) serve(0, d_first, la, 1'b0, 32'h0, 4'h0);
        else               serve(0, d_first, ia, 1'b0, 32'h0, 4'h0);
        #1;
        n_cmp++;
        if ({ifu_req_ready, lsu_req_ready} !== {exp_lsu_first, ~exp_lsu_first}) begin
            n_err++; $display("FAIL second_grant: got ifu=%b lsu=%b want ifu=%b lsu=%b",
                              ifu_req_ready, lsu_req_ready, exp_lsu_first, ~exp_lsu_first);
        end
        sb.push_back('{is_lsu: ~exp_lsu_first, data: d_second});
        check_rsp();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        if (exp_lsu_first) serve(0, d_second, ia, 1'b0, 32'h0, 4'h0);
        else               serve(0, d_second, la, 1'b0, 32'h0, 4'h0);
        check_rsp();
    endtask

    task automatic test_spurious_rsp();
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rdata = 0;
        @(negedge clk);
        n_cmp++;
        if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000) begin
            n_err++; $display("FAIL spurious_pulse: got ifu=%b lsu=%b memv=%b want 0 0 0",
                              ifu_rsp_valid, lsu_rsp_valid, mem_req_valid);
        end
        n_cmp++;
        if ({ifu_rdata, lsu_rdata} !== {model_ifu_rdata, model_lsu_rdata}) begin
            n_err++; $display("FAIL spurious_rdata: got ifu=%h lsu=%h want ifu=%h lsu=%h",
                              ifu_rdata, lsu_rdata, model_ifu_rdata, model_lsu_rdata);
        end
        // Probe that the FSM still sits in IDLE, withdrawing before the edge.
        ifu_req_valid = 1'b1; #1;
        n_cmp++;
        if (ifu_req_ready !== 1'b1) begin
            n_err++; $display("FAIL spurious_state: got ifu_req_ready=%b want 1", ifu_req_ready);
        end
        #1 ifu_req_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        drive_req(1'b0, 32'h8000_0100, 1'b0, 32'h0, 4'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ifu_rdata = 0; model_lsu_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rdata = 0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000) begin
                n_err++; $display("FAIL stale_pulse[%0d]: got ifu=%b lsu=%b memv=%b want 0 0 0",
                                  i, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid);
            end
            n_cmp++;
            if ({ifu_rdata, lsu_rdata, mem_addr} !== 96'h0) begin
                n_err++; $display("FAIL stale_data[%0d]: got ir=%h lr=%h a=%h want all 0",
                                  i, ifu_rdata, lsu_rdata, mem_addr);
            end
            @(negedge clk);
        end
        // Reset restores last-owner to LSU: RR grants IFU, fixed priority grants LSU.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; #1;
        n_cmp++;
        if ({ifu_req_ready, lsu_req_ready} !== {RrOn, ~RrOn}) begin
            n_err++; $display("FAIL post_reset_grant: got ifu=%b lsu=%b want ifu=%b lsu=%b",
                              ifu_req_ready, lsu_req_ready, RrOn, ~RrOn);
        end
        #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        // IFU was served last: both policies grant LSU first.
        test_back_to_back(1'b1, 32'h0000_00AA, 32'h0000_00BB);
        test_lsu_store();
        test_lsu_load();
        test_ifu_fetch();
        test_back_to_back(1'b1, 32'h5555_0001, 32'h6666_0002);
        test_lsu_load();
        // LSU was served last: round-robin now favours IFU.
        test_back_to_back(~RrOn, 32'h7777_0003, 32'h8888_0004);
        test_spurious_rsp();
        test_reset_in_wait();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_mem_arbiter.md
YSYX_22041211_MEM_ARBITER -- requirements
Module: ysyx_22041211_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 32, address width.
REQ-002 SHALL have parameter DATA_LEN, default 32, data width.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ifu_req_valid  input  1  IFU fetch request.
REQ-006 SHALL have ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-007 SHALL have ifu_addr  input  ADDR_LEN  IFU fetch address.
REQ-008 SHALL have ifu_rsp_valid  output  1  one-cycle pulse, IFU read data valid.
REQ-009 SHALL have ifu_rdata  output  DATA_LEN  fetched instruction word.
REQ-010 SHALL have lsu_req_valid  input  1  LSU load/store request.
REQ-011 SHALL have lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-012 SHALL have lsu_addr  input  ADDR_LEN  LSU address.
REQ-013 SHALL have lsu_wen  input  1  1 = store, 0 = load.
REQ-014 SHALL have lsu_wdata  input  DATA_LEN  store data.
REQ-015 SHALL have lsu_wmask  input  DATA_LEN/8  store byte enables.
REQ-016 SHALL have lsu_rsp_valid  output  1  one-cycle pulse, LSU access complete.
REQ-017 SHALL have lsu_rdata  output  DATA_LEN  load data.
REQ-018 SHALL have mem_req_valid  output  1  request to memory.
REQ-019 SHALL have mem_req_ready  input  1  memory accepts request.
REQ-020 SHALL have mem_addr / mem_wen / mem_wdata / mem_wmask  output  ADDR_LEN / 1 / DATA_LEN / DATA_LEN/8  registered request fields.
REQ-021 SHALL have mem_rsp_valid  input  1  memory response.
REQ-022 SHALL have mem_rdata  input  DATA_LEN  memory read data.

Function
REQ-023 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, one outstanding transaction at most.
REQ-024 IDLE: ready asserted combinationally to the single winner with req_valid high; handshake (valid && ready) latches addr/wen/wdata/wmask and owner, next state ISSUE; IFU requests latch wen=0, wmask=0.
REQ-025 ifu_req_ready and lsu_req_ready SHALL be 0 outside IDLE and never both 1.
REQ-026 ISSUE: mem_req_valid=1 with latched fields held stable until mem_req_ready=1; then WAIT.
REQ-027 WAIT: on mem_rsp_valid=1, owner's rsp_valid pulses 1 cycle later (registered), owner's rdata updated to mem_rdata, next state IDLE; non-owner unaffected.
REQ-028 Stores SHALL also produce lsu_rsp_valid; lsu_rdata then = mem_rdata as returned.
REQ-029 mem_rsp_valid in IDLE or ISSUE SHALL be ignored.
REQ-030 rdata outputs SHALL hold last value until next response to that owner.
REQ-031 Min latency: handshake cycle N, mem_req_valid N+1, with zero-wait memory (ready at N+1, rsp at N+2) rsp_valid at N+3; new grant possible at N+3.

Reset
REQ-032 rst=1 SHALL force IDLE, drop any in-flight transaction, all outputs and holding registers to 0, last-owner to LSU; responses arriving after reset are ignored.

Configuration
REQ-033 With YSYX_22041211_ARB_RR_EN defined, simultaneous requests SHALL be granted to the master not served last (round-robin); without it, LSU SHALL always win simultaneous requests.

Structure
REQ-034 Owner encoding (IFU=0, LSU=1) and FSM state encoding SHALL live in a shared package ysyx_22041211_bus_pkg.
REQ-035 The grant logic SHALL be a sub-module ysyx_22041211_arb_grant (two requests, last-owner, macro-controlled policy in, one-hot grant out).

Verification
REQ-036 IFU alone, addr 0x80000000, memory returns 0x00100073 next cycle -> ifu_rsp_valid pulse, ifu_rdata=0x00100073, lsu_rsp_valid stays 0.
REQ-037 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready delayed 3 cycles -> mem fields stable 3 cycles, one lsu_rsp_valid pulse.
REQ-038 Both request same cycle, macro off -> LSU granted first, IFU granted in the next IDLE; macro on after IFU just served -> LSU first, then IFU.
REQ-039 rst asserted in WAIT, stale mem_rsp_valid 2 cycles later -> no rsp_valid pulse, state IDLE, outputs 0.
REQ-040 Spurious mem_rsp_valid in IDLE with no requests -> no rsp_valid, state unchanged.
